// File: rtl/trail_pkg.sv
// trail_pkg: grid geometry, cell codes, FSM state encoding and address helper
// shared by the trail grid collision block and its RAM.
package trail_pkg;

   localparam int unsigned GRID_W   = 120;
   localparam int unsigned GRID_H   = 120;
   localparam int unsigned GRID_MIN = 3;
   localparam int unsigned GRID_MAX = 115;
   localparam int unsigned DEPTH    = GRID_W * GRID_H;
   localparam int unsigned ADDR_W   = 14;

   localparam logic [2:0] GS_SPAWN = 3'd1;
   localparam logic [2:0] GS_PLAY  = 3'd2;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_BLUE  = 2'd1,
      CELL_RED   = 2'd2
   } cell_t;

   typedef enum logic [2:0] {
      CLEAR = 3'd0,
      IDLE  = 3'd1,
      RD_B  = 3'd2,
      RD_R  = 3'd3,
      EVAL  = 3'd4,
      WR_B  = 3'd5,
      WR_R  = 3'd6
   } state_t;

   // Row-major cell address; callers only use it for in-grid coordinates.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] x, input logic [7:0] y);
      return ADDR_W'(32'(y) * GRID_W + 32'(x));
   endfunction

endpackage

// File: rtl/trail_grid_if.sv
// trail_grid_if: bike positions, game state and frame strobe in; collision
// flags, clear status and the video read port out.
interface trail_grid_if;
   logic       frame_clk;
   logic [2:0] Game_State;
   logic [7:0] Blue_X;
   logic [7:0] Blue_Y;
   logic [7:0] Red_X;
   logic [7:0] Red_Y;
   logic [7:0] rd_x;
   logic [7:0] rd_y;
   logic [1:0] rd_cell;
   logic       collision_blue;
   logic       collision_red;
   logic       clearing;

   modport master (
      output frame_clk, Game_State, Blue_X, Blue_Y, Red_X, Red_Y, rd_x, rd_y,
      input  rd_cell, collision_blue, collision_red, clearing
   );

   modport slave (
      input  frame_clk, Game_State, Blue_X, Blue_Y, Red_X, Red_Y, rd_x, rd_y,
      output rd_cell, collision_blue, collision_red, clearing
   );
endinterface

// File: rtl/trail_ram.sv
// trail_ram: 2-bit-per-cell trail storage. Port A read/write for the FSM,
// port B read-only for video; both reads registered with one cycle latency.
module trail_ram
   import trail_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              a_en,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [1:0]        a_wdata,
   output logic [1:0]        a_rdata,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [1:0]        b_rdata
);

   logic [1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (a_en) begin
         if (a_we) begin
            mem[a_addr] <= a_wdata;
         end else begin
            a_rdata <= mem[a_addr];
         end
      end
   end

   // Addresses past the grid read as empty rather than aliasing into it.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_rdata <= '0;
      end else if (b_addr < ADDR_W'(DEPTH)) begin
         b_rdata <= mem[b_addr];
      end else begin
         b_rdata <= '0;
      end
   end

endmodule

// File: rtl/trail_grid.sv
// trail_grid: once per frame checks both bike heads against the trail grid,
// flags crashes, then records new heads. Define TRAIL_WALL_CHECK_EN to add walls.
//
// state | meaning
// CLEAR | zeroing the grid, one cell per cycle
// IDLE  | waiting for a frame pulse in play
// RD_B  | read issued for blue head cell
// RD_R  | blue cell captured, read issued for red head cell
// EVAL  | red cell arrives, collisions resolved
// WR_B  | blue trail write when allowed
// WR_R  | red trail write when allowed
module trail_grid
   import trail_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   trail_grid_if.slave bus
);

   localparam logic [7:0] W8 = 8'(GRID_W);
   localparam logic [7:0] H8 = 8'(GRID_H);
`ifdef TRAIL_WALL_CHECK_EN
   localparam logic [7:0] MIN8 = 8'(GRID_MIN);
   localparam logic [7:0] MAX8 = 8'(GRID_MAX);
`endif

   function automatic logic off_grid(input logic [7:0] x, input logic [7:0] y);
`ifdef TRAIL_WALL_CHECK_EN
      return (x < MIN8) || (x > MAX8) || (y < MIN8) || (y > MAX8) || (x >= W8) || (y >= H8);
`else
      return (x >= W8) || (y >= H8);
`endif
   endfunction

   state_t            state;
   logic              frame_d;
   logic              frame_pulse;
   logic [2:0]        gs_d;
   logic              gs_enter;
   logic [ADDR_W-1:0] clr_cnt;
   logic [7:0]        bx, by, rx, ry;
   logic [15:0]       last_b, last_r;
   logic              last_b_ok, last_r_ok;
   logic [1:0]        data_b;
   logic              wr_b_ok, wr_r_ok;
   logic              col_b, col_r, clearing;

   logic              off_b, off_r, new_b, new_r, head_on, hit_b, hit_r;
   logic [1:0]        cell_r;
   logic [ADDR_W-1:0] addr_b, addr_r, vid_addr;

   logic              a_en, a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [1:0]        a_wdata, ram_q;

   assign gs_enter = (bus.Game_State == GS_SPAWN) && (gs_d != GS_SPAWN);

   assign off_b   = off_grid(bx, by);
   assign off_r   = off_grid(rx, ry);
   assign addr_b  = off_b ? '0 : cell_addr(bx, by);
   assign addr_r  = off_r ? '0 : cell_addr(rx, ry);
   assign new_b   = !last_b_ok || (last_b != {by, bx});
   assign new_r   = !last_r_ok || (last_r != {ry, rx});
   assign head_on = new_b && new_r && ({by, bx} == {ry, rx});
   // No read was issued for an off-grid bike, so the RAM output is stale there.
   assign cell_r  = off_r ? 2'b00 : ram_q;
   assign hit_b   = new_b && (off_b || (data_b != 2'b00) || head_on);
   assign hit_r   = new_r && (off_r || (cell_r != 2'b00) || head_on);

   assign vid_addr = ((bus.rd_x < W8) && (bus.rd_y < H8)) ? cell_addr(bus.rd_x, bus.rd_y)
                                                          : ADDR_W'(DEPTH);

   always_comb begin
      a_en    = 1'b0;
      a_we    = 1'b0;
      a_addr  = addr_b;
      a_wdata = CELL_EMPTY;
      unique case (state)
         CLEAR: begin
            a_en   = 1'b1;
            a_we   = 1'b1;
            a_addr = clr_cnt;
         end
         RD_B: a_en = !off_b;
         RD_R: begin
            a_en   = !off_r;
            a_addr = addr_r;
         end
         WR_B: begin
            a_en    = wr_b_ok;
            a_we    = 1'b1;
            a_wdata = CELL_BLUE;
         end
         WR_R: begin
            a_en    = wr_r_ok;
            a_we    = 1'b1;
            a_addr  = addr_r;
            a_wdata = CELL_RED;
         end
         default: ;
      endcase
   end

   // Registered rising-edge pulse lines up with the position block's update.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_d     <= 1'b0;
         frame_pulse <= 1'b0;
      end else begin
         frame_d     <= bus.frame_clk;
         frame_pulse <= bus.frame_clk && !frame_d;
      end
   end

   always_ff @(posedge Clk) begin
      gs_d <= bus.Game_State;
      if (Reset || gs_enter) begin
         state     <= CLEAR;
         clr_cnt   <= '0;
         col_b     <= 1'b0;
         col_r     <= 1'b0;
         clearing  <= 1'b1;
         last_b_ok <= 1'b0;
         last_r_ok <= 1'b0;
         wr_b_ok   <= 1'b0;
         wr_r_ok   <= 1'b0;
      end else begin
         unique case (state)
            CLEAR: begin
               if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                  state    <= IDLE;
                  clearing <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (frame_pulse && (bus.Game_State == GS_PLAY)) begin
                  bx    <= bus.Blue_X;
                  by    <= bus.Blue_Y;
                  rx    <= bus.Red_X;
                  ry    <= bus.Red_Y;
                  state <= RD_B;
               end
            end
            RD_B: state <= RD_R;
            RD_R: begin
               data_b <= off_b ? 2'b00 : ram_q;
               state  <= EVAL;
            end
            EVAL: begin
               col_b   <= col_b | hit_b;
               col_r   <= col_r | hit_r;
               wr_b_ok <= new_b && !hit_b && !col_b;
               wr_r_ok <= new_r && !hit_r && !col_r;
               state   <= WR_B;
            end
            WR_B: begin
               if (wr_b_ok) begin
                  last_b    <= {by, bx};
                  last_b_ok <= 1'b1;
               end
               state <= WR_R;
            end
            WR_R: begin
               if (wr_r_ok) begin
                  last_r    <= {ry, rx};
                  last_r_ok <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.collision_blue = col_b;
   assign bus.collision_red  = col_r;
   assign bus.clearing       = clearing;

   trail_ram u_ram (
      .clk     (Clk),
      .rst     (Reset),
      .a_en    (a_en),
      .a_we    (a_we),
      .a_addr  (a_addr),
      .a_wdata (a_wdata),
      .a_rdata (ram_q),
      .b_addr  (vid_addr),
      .b_rdata (bus.rd_cell)
   );

endmodule
